// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the MIPS multiply/divide unit.
package mips_muldiv_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_CNT_W = $clog2(MD_WIDTH);

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIVU  = 3'b010,
    OP_MTHI  = 3'b011,
    OP_MTLO  = 3'b100,
    OP_MULT  = 3'b101,
    OP_DIV   = 3'b110,
    OP_NOP7  = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/mips_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference when it does not borrow.
module mips_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_c,
  output logic [WIDTH-1:0] quo_c
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtract; bit WIDTH of the difference is the borrow.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, div_i};
    if (!diff[WIDTH]) begin
      rem_c = diff[WIDTH-1:0];
      quo_c = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_c = shifted[WIDTH-1:0];
      quo_c = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mips_muldiv_hilo.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Optional feature macro: MULDIV_SIGNED_EN (signed MULT/DIV with sign fix-up).
module mips_muldiv_hilo
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  md_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q;

  logic             is_mul_c, is_div_c, is_signed_c, last_c;
  logic [WIDTH-1:0] a_abs_c, b_abs_c;
  logic [WIDTH:0]   mul_sum_c;
  logic [WIDTH-1:0] div_rem_c, div_quo_c;
  logic [WIDTH-1:0] step_hi_c, step_lo_c, res_hi_c, res_lo_c;

`ifdef MULDIV_SIGNED_EN
  logic             neg_p_q, neg_r_q;
  logic [2*WIDTH-1:0] prod_neg_c;
`endif

  // Opcode decode and operand magnitudes.
  always_comb begin
    is_mul_c = (op_i == OP_MULTU) || (op_i == OP_MULT);
    is_div_c = (op_i == OP_DIVU) || (op_i == OP_DIV);
`ifdef MULDIV_SIGNED_EN
    is_signed_c = (op_i == OP_MULT) || (op_i == OP_DIV);
`else
    is_signed_c = 1'b0;
`endif
    a_abs_c = (is_signed_c && a_i[WIDTH-1]) ? WIDTH'(0) - a_i : a_i;
    b_abs_c = (is_signed_c && b_i[WIDTH-1]) ? WIDTH'(0) - b_i : b_i;
  end

  mips_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (acc_hi_q),
    .quo_i (acc_lo_q),
    .div_i (opnd_q),
    .rem_c (div_rem_c),
    .quo_c (div_quo_c)
  );

  // One shift-add multiply step, muxed against the divide step.
  always_comb begin
    mul_sum_c = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    if (state_q == S_DIV) begin
      step_hi_c = div_rem_c;
      step_lo_c = div_quo_c;
    end else begin
      step_hi_c = mul_sum_c[WIDTH:1];
      step_lo_c = {mul_sum_c[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  // Result written to HI/LO on the final iteration edge, sign-corrected if enabled.
  always_comb begin
    res_hi_c = step_hi_c;
    res_lo_c = step_lo_c;
`ifdef MULDIV_SIGNED_EN
    prod_neg_c = (2*WIDTH)'(0) - {step_hi_c, step_lo_c};
    if (neg_p_q) begin
      if (state_q == S_MUL) {res_hi_c, res_lo_c} = prod_neg_c;
      else                  res_lo_c = WIDTH'(0) - step_lo_c;
    end
    if ((state_q == S_DIV) && neg_r_q) res_hi_c = WIDTH'(0) - step_hi_c;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    last_c  = (cnt_q == CW'(WIDTH - 1));
    case (state_q)
      S_IDLE: begin
        if (start_i && is_mul_c)      state_d = S_MUL;
        else if (start_i && is_div_c) state_d = S_DIV;
      end
      S_MUL, S_DIV: if (last_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath, HI/LO and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
`endif
    end else begin
      busy_q <= (state_d != S_IDLE);
      done_q <= (state_d == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (is_mul_c || is_div_c) begin
              cnt_q    <= '0;
              acc_hi_q <= '0;
              acc_lo_q <= is_mul_c ? b_abs_c : a_abs_c;
              opnd_q   <= is_mul_c ? a_abs_c : b_abs_c;
`ifdef MULDIV_SIGNED_EN
              // Zero divisor keeps the all-ones quotient unnegated.
              neg_p_q <= is_signed_c && (a_i[WIDTH-1] ^ b_i[WIDTH-1])
                         && !(is_div_c && (b_i == '0));
              neg_r_q <= is_signed_c && is_div_c && a_i[WIDTH-1];
`endif
            end
            if (op_i == OP_MTHI) hi_q <= a_i;
            if (op_i == OP_MTLO) lo_q <= a_i;
          end
        end
        S_MUL, S_DIV: begin
          acc_hi_q <= step_hi_c;
          acc_lo_q <= step_lo_c;
          cnt_q    <= cnt_q + CW'(1);
          if (last_c) begin
            hi_q <= res_hi_c;
            lo_q <= res_lo_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
